// File: rtl/multi_timer.sv
// multi_timer: multi-channel down-counting timer with shared prescaler, sticky status and masked irq
module multi_timer #(
    parameter  int WIDTH      = 16,
    parameter  int NCH        = 4,
    parameter  int PRESCALE_W = 8,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [1:0]            setup,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [NCH-1:0]        restart,
    input  logic [NCH-1:0]        enable,
    input  logic [NCH-1:0]        auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [NCH-1:0]        status_clr,
    input  logic [NCH-1:0]        irq_en,
    output logic [NCH*WIDTH-1:0]  count_out,
    output logic [NCH-1:0]        match,
    output logic [NCH-1:0]        status,
    output logic                  irq
);
    logic [PRESCALE_W-1:0] psc_cnt;
    logic                  tick;

    assign tick = psc_cnt >= prescale;

    // prescaler; the >= compare makes a lowered prescale fire on the next cycle instead of wrapping
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) psc_cnt <= '0;
        else psc_cnt <= tick ? '0 : psc_cnt + 1'b1;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] reload;
        logic             match_q;
        logic             status_q;
        logic             sel;
        logic             load_hit;
        logic             dec;

        assign sel      = ch_sel == CH_W'(i);
        assign load_hit = setup == 2'b11 && sel;
        assign dec      = tick && enable[i] && cnt != '0;

        // reload register is written by both setup forms; out-of-range ch_sel never matches
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) reload <= '0;
            else if (setup[1] && sel) reload <= load_value;

        // counter: load beats restart beats decrement beats auto-reload
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) cnt <= '0;
            else if (load_hit) cnt <= load_value;
            else if (restart[i]) cnt <= reload;
            else if (dec) cnt <= cnt - 1'b1;
            else if (tick && enable[i] && auto_reload[i]) cnt <= reload;

        // match pulses only when a decrement lands on zero; status set wins over clear
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                match_q  <= 1'b0;
                status_q <= 1'b0;
            end else begin
                match_q  <= !load_hit && !restart[i] && dec && cnt == WIDTH'(1);
                status_q <= match_q | (status_q & ~status_clr[i]);
            end

        assign count_out[i*WIDTH +: WIDTH] = cnt;
        assign match[i]                    = match_q;
        assign status[i]                   = status_q;
    end

    // irq is registered from the masked status, so it lags status by one cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) irq <= 1'b0;
        else irq <= |(status & irq_en);
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: scoreboard bench for multi_timer with a tick-count reference model
module tb_multi_timer;
    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     ch_sel;
    logic [1:0]     setup;
    logic [W-1:0]   load_value;
    logic [N-1:0]   restart, enable, auto_reload, status_clr, irq_en;
    logic [7:0]     prescale;
    logic [N*W-1:0] count_out;
    logic [N-1:0]   match, status;
    logic           irq;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int exp_q[$];

    multi_timer #(.WIDTH(W), .NCH(N), .PRESCALE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ch_sel(ch_sel), .setup(setup), .load_value(load_value),
        .restart(restart), .enable(enable), .auto_reload(auto_reload), .prescale(prescale),
        .status_clr(status_clr), .irq_en(irq_en), .count_out(count_out), .match(match),
        .status(status), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every match pulse must correspond to a predicted (channel, cycle) entry
    always @(negedge clk)
        if (rst_n)
            for (int i = 0; i < N; i++)
                if (match[i]) begin
                    automatic int k = cyc * 16 + i;
                    automatic int idx = -1;
                    foreach (exp_q[j]) if (exp_q[j] == k) idx = j;
                    total++;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL match_ch%0d: got pulse at cycle %0d, want none", i, cyc);
                    end else exp_q.delete(idx);
                end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drain(input string tag);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_sb: got %0d missing pulses (first ch%0d cycle %0d) want 0",
                     tag, exp_q.size(), exp_q[0] % 16, exp_q[0] / 16);
            exp_q.delete();
        end
    endtask

    task automatic expect_m(input int ch, input int c);
        exp_q.push_back(c * 16 + ch);
    endtask

    task automatic load(input int ch, input int v);
        ch_sel = ch[1:0];
        setup = 2'b11;
        load_value = v[W-1:0];
        step();
        setup = 2'b00;
    endtask

    function automatic int cnt(input int ch);
        return int'(count_out[ch*W +: W]);
    endfunction

    // counter value after nt enabled ticks from a fresh load of l
    function automatic int model_cnt(input int l, input logic au, input int nt);
        int r;
        if (l == 0) return 0;
        if (nt < l) return l - nt;
        if (!au) return 0;
        r = (nt - l) % (l + 1);
        return r == 0 ? 0 : l + 1 - r;
    endfunction

    // reset, load all channels, then run len enabled cycles; ticks land every p+1 cycles after reset
    task automatic sched(input int p, input int lv[N], input logic [N-1:0] au, input int len, input string tag);
        int r1, eon, wend, nt;
        logic [N-1:0] hit;
        rst_n = 1'b0;
        enable = '0;
        auto_reload = au;
        prescale = p[7:0];
        irq_en = '0;
        step();
        rst_n = 1'b1;
        r1 = cyc + 1;
        for (int i = 0; i < N; i++) load(i, lv[i]);
        enable = '1;
        eon = cyc + 1;
        wend = eon + len - 1;
        nt = 0;
        hit = '0;
        for (int e = eon; e <= wend; e++)
            if (e - r1 - p >= 0 && (e - r1 - p) % (p + 1) == 0) begin
                nt++;
                for (int i = 0; i < N; i++)
                    if (lv[i] > 0 && (nt == lv[i] || (au[i] && nt > lv[i] && (nt - lv[i]) % (lv[i] + 1) == 0))) begin
                        expect_m(i, e);
                        hit[i] = 1'b1;
                    end
            end
        step(len);
        enable = '0;
        step(2);
        drain(tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i), cnt(i), model_cnt(lv[i], au[i], nt));
            chk($sformatf("%s_status%0d", tag, i), status[i], hit[i]);
        end
    endtask

    initial begin
        int lv[N];
        ch_sel = 0; setup = 0; load_value = 0; restart = 0; enable = 0;
        auto_reload = 0; prescale = 0; status_clr = 0; irq_en = 0;
        step();
        chk("rst_count", count_out, 0);
        chk("rst_match", match, 0);
        chk("rst_status", status, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        // one-shot
        enable = 4'b0001;
        load(0, 9);
        expect_m(0, cyc + 9);
        step(12);
        chk("t2_cnt", cnt(0), 0);
        chk("t2_status", status[0], 1);
        step(5);
        chk("t2_hold", cnt(0), 0);
        drain("t2");
        // reset mid-count
        irq_en = 4'b0001;
        load(0, 9);
        step(4);
        chk("t1_cnt5", cnt(0), 5);
        chk("t1_irq_pre", irq, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_count", count_out, 0);
        chk("t1_match", match, 0);
        chk("t1_status", status, 0);
        chk("t1_irq", irq, 0);
        step(2);
        rst_n = 1'b1;
        step(15);
        chk("t1_after", count_out, 0);
        drain("t1");
        irq_en = 0;
        // collisions on ch2
        enable = 0;
        ch_sel = 2; setup = 2'b10; load_value = 16'h55;
        step();
        setup = 0;
        chk("t4_setup10_nocnt", cnt(2), 0);
        setup = 2'b11; load_value = 16'h30; restart = 4'b0100;
        step();
        setup = 0; restart = 0;
        chk("t4_load_vs_restart", cnt(2), 16'h30);
        setup = 2'b10; load_value = 16'h77; restart = 4'b0100;
        step();
        setup = 0; restart = 0;
        chk("t4_restart_old_reload", cnt(2), 16'h30);
        restart = 4'b0100;
        step();
        restart = 0;
        chk("t4_restart_new", cnt(2), 16'h77);
        enable = 4'b0100;
        load(2, 3);
        expect_m(2, cyc + 3);
        step(3);
        chk("t4_match_now", match[2], 1);
        status_clr = 4'b0100;
        step();
        status_clr = 0;
        chk("t4_set_wins", status[2], 1);
        status_clr = 4'b0100;
        step();
        status_clr = 0;
        chk("t4_clr", status[2], 0);
        drain("t4");
        // irq masking
        enable = 4'b1000;
        load(3, 2);
        expect_m(3, cyc + 2);
        step(4);
        chk("t6_status", status[3], 1);
        chk("t6_irq_masked", irq, 0);
        irq_en = 4'b1000;
        chk("t6_irq_lag", irq, 0);
        step();
        chk("t6_irq_on", irq, 1);
        status_clr = 4'b1000;
        step();
        status_clr = 0;
        chk("t6_status_clr", status[3], 0);
        chk("t6_irq_still", irq, 1);
        step();
        chk("t6_irq_off", irq, 0);
        drain("t6");
        // auto-reload with prescale, then independent periods
        lv = '{0, 7, 0, 0};
        sched(3, lv, 4'b0010, 130, "t3");
        lv = '{15, 7, 10, 127};
        sched(0, lv, 4'b1111, 300, "t5");
        // randomized schedules
        for (int r = 0; r < 4; r++) begin
            int p;
            logic [N-1:0] au;
            p = int'($urandom_range(0, 3));
            au = N'($urandom);
            for (int i = 0; i < N; i++) lv[i] = int'($urandom_range(0, 40));
            sched(p, lv, au, 160, $sformatf("rnd%0d", r));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
